// File: rtl/ahbl_slv_mem_bridge.sv
// Purpose: terminates AHB-Lite transfers as single-beat req/gnt/rvalid memory requests.
// Latency: write completes zero-wait when mem_gnt is high; read needs gnt plus rvalid, then one ready cycle.
// Backpressure: mem_gnt low or rvalid pending holds hreadyout low; illegal size/alignment gives a two-cycle ERROR.
//
// Ports:
//   hclk, hreset          clock, asynchronous active-high reset
//   hsel..hwdata, hready  AHB-Lite slave inputs (hburst/hprot accepted, unused)
//   hreadyout, hresp      slave ready and response (00 OKAY, 01 ERROR)
//   hrdata                registered read data, updated only when read data returns
//   mem_req..mem_wdata    memory request side (word address, byte enables)
//   mem_gnt, mem_rvalid,  memory grant, read-data valid and read data
//   mem_rdata
module ahbl_slv_mem_bridge #(
    parameter  int AW  = 32,
    parameter  int DW  = 32,
    localparam int BW  = DW / 8,
    localparam int MAW = AW - $clog2(BW)
) (
    input  logic           hclk,
    input  logic           hreset,
    input  logic           hsel,
    input  logic [1:0]     htrans,
    input  logic [AW-1:0]  haddr,
    input  logic [2:0]     hsize,
    input  logic [2:0]     hburst,
    input  logic [1:0]     hprot,
    input  logic           hwrite,
    input  logic [DW-1:0]  hwdata,
    input  logic           hready,
    output logic           hreadyout,
    output logic [1:0]     hresp,
    output logic [DW-1:0]  hrdata,
    output logic           mem_req,
    output logic           mem_we,
    output logic [MAW-1:0] mem_addr,
    output logic [BW-1:0]  mem_be,
    output logic [DW-1:0]  mem_wdata,
    input  logic           mem_gnt,
    input  logic           mem_rvalid,
    input  logic [DW-1:0]  mem_rdata
);

    localparam int         BSH   = $clog2(BW);
    localparam logic [1:0] OKAY  = 2'b00;
    localparam logic [1:0] ERROR = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD_REQ,
        S_RD_WAIT,
        S_RD_DONE,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t         state, state_n;
    state_t         pick;
    logic           accept;
    logic           take;
    logic           acc_err;
    logic [MAW-1:0] waddr_q;
    logic [BW-1:0]  be_q;

    // hburst, hprot and the SEQ/NONSEQ distinction do not change behaviour.
    logic unused_ok;
    assign unused_ok = ^{hburst, hprot, htrans[0]};

    // 2^sz contiguous lanes starting at the byte offset.
    function automatic logic [BW-1:0] be_calc(input logic [2:0] sz, input logic [BSH-1:0] off);
        logic [BW-1:0] m;
        for (int i = 0; i < BW; i++) begin
            m[i] = (i < (1 << sz));
        end
        return m << off;
    endfunction

    // Any offset bit below the transfer size makes the access misaligned.
    function automatic logic misaligned(input logic [2:0] sz, input logic [BSH-1:0] off);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < BSH; i++) begin
            if ((i < int'(sz)) && off[i]) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    assign accept  = hsel & htrans[1] & hready;
    // Capture only when this slave is ready, so an in-flight transfer is never overwritten.
    assign take    = accept & hreadyout;
    assign acc_err = (hsize > 3'(BSH)) | misaligned(hsize, haddr[BSH-1:0]);

    assign pick      = acc_err ? S_ERR1 : (hwrite ? S_WR : S_RD_REQ);
    assign mem_wdata = hwdata;
    assign mem_addr  = waddr_q;
    assign mem_be    = be_q;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state   <= S_IDLE;
            waddr_q <= '0;
            be_q    <= '0;
            hrdata  <= '0;
        end else begin
            state <= state_n;
            if (take) begin
                waddr_q <= haddr[AW-1:BSH];
                be_q    <= be_calc(hsize, haddr[BSH-1:0]);
            end
            if ((state == S_RD_WAIT) && mem_rvalid) begin
                hrdata <= mem_rdata;
            end
        end
    end

    // In every ready state the branch below only runs while hreadyout=1,
    // so testing accept there is equivalent to testing take.
    always_comb begin
        state_n   = state;
        hreadyout = 1'b1;
        hresp     = OKAY;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        case (state)
            S_IDLE: begin
                state_n = accept ? pick : S_IDLE;
            end
            S_WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                hreadyout = mem_gnt;
                if (mem_gnt) begin
                    state_n = accept ? pick : S_IDLE;
                end
            end
            S_RD_REQ: begin
                mem_req   = 1'b1;
                hreadyout = 1'b0;
                if (mem_gnt) begin
                    state_n = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                hreadyout = 1'b0;
                if (mem_rvalid) begin
                    state_n = S_RD_DONE;
                end
            end
            S_RD_DONE: begin
                state_n = accept ? pick : S_IDLE;
            end
            S_ERR1: begin
                hreadyout = 1'b0;
                hresp     = ERROR;
                state_n   = S_ERR2;
            end
            S_ERR2: begin
                hresp   = ERROR;
                state_n = accept ? pick : S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ahbl_slv_mem_bridge.sv
// Purpose: scoreboard bench for ahbl_slv_mem_bridge (expected memory requests and AHB responses queued by stimulus).
// Latency: expected wait-state counts are hand-computed per transfer.
// Backpressure: memory responder with programmable grant delay and read-data delay.
module tb_ahbl_slv_mem_bridge;

    localparam int AW = 32;
    localparam int DW = 32;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        hsel;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [1:0]  hprot;
    logic        hwrite;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic [1:0]  hresp;
    logic [31:0] hrdata;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    always #5 hclk = ~hclk;

    // Single slave on the bus: bus ready follows this slave.
    assign hready = hreadyout;

    ahbl_slv_mem_bridge #(.AW(AW), .DW(DW)) dut (
        .hclk(hclk), .hreset(hreset), .hsel(hsel), .htrans(htrans), .haddr(haddr),
        .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwrite(hwrite), .hwdata(hwdata),
        .hready(hready), .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    typedef struct {
        int          id;
        bit          we;
        logic [29:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mem_exp_t;

    typedef struct {
        int          id;
        bit          rd;
        int          waits;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } rsp_exp_t;

    mem_exp_t exp_mem[$];
    rsp_exp_t exp_rsp[$];

    int n_chk  = 0;
    int n_pass = 0;
    int next_id = 0;

    int          gnt_dly  = 0;
    int          rv_dly   = 1;
    int          rv_timer = 0;
    int          gcnt     = 0;
    logic [31:0] rd_val   = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic push_mem(input bit we, input logic [29:0] a, input logic [3:0] be, input logic [31:0] wd);
        mem_exp_t e;
        e.id = next_id; e.we = we; e.addr = a; e.be = be; e.wdata = wd;
        next_id++;
        exp_mem.push_back(e);
    endtask

    task automatic push_rsp(input bit rd, input int w, input logic [1:0] r, input logic [31:0] d);
        rsp_exp_t e;
        e.id = next_id; e.rd = rd; e.waits = w; e.resp = r; e.rdata = d;
        next_id++;
        exp_rsp.push_back(e);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_hreadyout"}, 64'(hreadyout), 64'd1);
        chk({tag, "_hresp"},     64'(hresp),     64'd0);
        chk({tag, "_hrdata"},    64'(hrdata),    64'd0);
        chk({tag, "_mem_req"},   64'(mem_req),   64'd0);
        chk({tag, "_mem_we"},    64'(mem_we),    64'd0);
        chk({tag, "_mem_addr"},  64'(mem_addr),  64'd0);
        chk({tag, "_mem_be"},    64'(mem_be),    64'd0);
    endtask

    // Non-pipelined transfer: address phase until accepted, then data phase until hreadyout.
    task automatic xfer(input bit wr, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
        int k;
        @(posedge hclk); #1;
        hsel = 1'b1; htrans = 2'b10; haddr = a; hsize = sz; hwrite = wr;
        k = 0;
        @(negedge hclk);
        while (!hready && k < 50) begin @(negedge hclk); k++; end
        if (!hready) begin
            n_chk++;
            $display("FAIL addr_phase_timeout: addr %0h never accepted", a);
        end
        @(posedge hclk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = wd;
        wait_ready(a);
    endtask

    task automatic wait_ready(input logic [31:0] a);
        int k;
        k = 0;
        @(negedge hclk);
        while (!hreadyout && k < 50) begin @(negedge hclk); k++; end
        if (!hreadyout) begin
            n_chk++;
            $display("FAIL data_phase_timeout: addr %0h hreadyout stuck %0b", a, hreadyout);
        end
    endtask

    // Memory responder: grant after gnt_dly cycles of mem_req, read data rv_dly cycles after grant.
    initial begin
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(posedge hclk); #1;
            mem_rvalid = 1'b0;
            if (rv_timer > 0) begin
                rv_timer--;
                if (rv_timer == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rd_val;
                end
            end
            if (mem_req) begin
                if (gcnt >= gnt_dly) begin mem_gnt = 1'b1; gcnt = 0; end
                else begin mem_gnt = 1'b0; gcnt++; end
            end else begin
                mem_gnt = 1'b0; gcnt = 0;
            end
            @(negedge hclk);
            if (mem_req && mem_gnt && !mem_we) rv_timer = rv_dly;
        end
    end

    // Monitor: pops expectations as the DUT issues memory requests and completes data phases.
    initial begin
        bit in_dp;
        int waits;
        mem_exp_t m;
        rsp_exp_t r;
        in_dp = 1'b0; waits = 0;
        forever begin
            @(negedge hclk);
            if (hreset) begin
                in_dp = 1'b0;
                continue;
            end
            if (mem_req && mem_gnt) begin
                if (exp_mem.size() == 0) begin
                    n_chk++;
                    $display("FAIL mem_unexpected: req we=%0b addr=%0h be=%0h, none expected", mem_we, mem_addr, mem_be);
                end else begin
                    m = exp_mem.pop_front();
                    chk($sformatf("t%0d_mem_we", m.id),   64'(mem_we),   64'(m.we));
                    chk($sformatf("t%0d_mem_addr", m.id), 64'(mem_addr), 64'(m.addr));
                    chk($sformatf("t%0d_mem_be", m.id),   64'(mem_be),   64'(m.be));
                    if (m.we) chk($sformatf("t%0d_mem_wdata", m.id), 64'(mem_wdata), 64'(m.wdata));
                end
            end
            if (in_dp) begin
                if (hreadyout) begin
                    in_dp = 1'b0;
                    if (exp_rsp.size() == 0) begin
                        n_chk++;
                        $display("FAIL rsp_unexpected: completion hresp=%0h, none expected", hresp);
                    end else begin
                        r = exp_rsp.pop_front();
                        chk($sformatf("t%0d_waits", r.id), 64'(waits), 64'(r.waits));
                        chk($sformatf("t%0d_hresp", r.id), 64'(hresp), 64'(r.resp));
                        if (r.rd) chk($sformatf("t%0d_hrdata", r.id), 64'(hrdata), 64'(r.rdata));
                    end
                end else begin
                    waits++;
                end
            end
            if (hsel && htrans[1] && hready) begin
                in_dp = 1'b1;
                waits = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        hsel = 1'b0; htrans = 2'b00; haddr = '0; hsize = 3'd0; hburst = 3'd0;
        hprot = 2'd0; hwrite = 1'b0; hwdata = '0; hreset = 1'b1;
        repeat (3) @(posedge hclk);
        #1;
        check_reset_vals("reset");
        hreset = 1'b0;

        // Word write, zero wait.
        gnt_dly = 0; rv_dly = 1;
        push_mem(1'b1, 30'h4, 4'hF, 32'hDEADBEEF);
        push_rsp(1'b0, 0, 2'b00, 32'h0);
        xfer(1'b1, 32'h10, 3'd2, 32'hDEADBEEF);

        // Word read, two grant stalls, data three cycles after grant: six waits.
        gnt_dly = 2; rv_dly = 3; rd_val = 32'h12345678;
        push_mem(1'b0, 30'h4, 4'hF, 32'h0);
        push_rsp(1'b1, 6, 2'b00, 32'h12345678);
        xfer(1'b0, 32'h10, 3'd2, 32'h0);
        gnt_dly = 0; rv_dly = 1;

        // Byte write at 0x13, halfword write at 0x12.
        push_mem(1'b1, 30'h4, 4'h8, 32'hAA000000);
        push_rsp(1'b0, 0, 2'b00, 32'h0);
        xfer(1'b1, 32'h13, 3'd0, 32'hAA000000);
        push_mem(1'b1, 30'h4, 4'hC, 32'h55550000);
        push_rsp(1'b0, 0, 2'b00, 32'h0);
        xfer(1'b1, 32'h12, 3'd1, 32'h55550000);

        // Errors: misaligned halfword, oversize, misaligned word. No memory traffic.
        push_rsp(1'b0, 1, 2'b01, 32'h0);
        xfer(1'b0, 32'h01, 3'd1, 32'h0);
        push_rsp(1'b0, 1, 2'b01, 32'h0);
        xfer(1'b1, 32'h00, 3'd3, 32'h0);
        push_rsp(1'b0, 1, 2'b01, 32'h0);
        xfer(1'b0, 32'h02, 3'd2, 32'h0);

        // Back-to-back NONSEQ write 0x20 then read 0x24.
        rd_val = 32'hCAFEF00D;
        push_mem(1'b1, 30'h8, 4'hF, 32'h0BADF00D);
        push_rsp(1'b0, 0, 2'b00, 32'h0);
        push_mem(1'b0, 30'h9, 4'hF, 32'h0);
        push_rsp(1'b1, 2, 2'b00, 32'hCAFEF00D);
        @(posedge hclk); #1;
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h20; hsize = 3'd2; hwrite = 1'b1;
        @(negedge hclk);
        @(posedge hclk); #1;
        hwdata = 32'h0BADF00D; haddr = 32'h24; hwrite = 1'b0;
        @(negedge hclk);
        @(posedge hclk); #1;
        hsel = 1'b0; htrans = 2'b00;
        wait_ready(32'h24);
        @(posedge hclk); #1;
        chk("hrdata_hold", 64'(hrdata), 64'h00000000CAFEF00D);
        chk("req_drop_idle", 64'(mem_req), 64'd0);

        // Reset while waiting for read data; late rvalid must be ignored.
        rv_dly = 4; rd_val = 32'h77778888;
        push_mem(1'b0, 30'h10, 4'hF, 32'h0);
        @(posedge hclk); #1;
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h40; hsize = 3'd2; hwrite = 1'b0;
        @(negedge hclk);
        @(posedge hclk); #1;
        hsel = 1'b0; htrans = 2'b00;
        @(posedge hclk); #1;
        chk("rdwait_req", 64'(mem_req), 64'd0);
        chk("rdwait_ready", 64'(hreadyout), 64'd0);
        hreset = 1'b1;
        @(posedge hclk); #1;
        check_reset_vals("midreset");
        @(posedge hclk); #1;
        hreset = 1'b0;
        @(posedge hclk); #1;
        @(posedge hclk); #1;
        chk("late_rvalid_hrdata", 64'(hrdata), 64'd0);
        chk("post_reset_ready", 64'(hreadyout), 64'd1);
        chk("post_reset_req", 64'(mem_req), 64'd0);
        hsel = 1'b1; htrans = 2'b00; haddr = 32'h0; hwrite = 1'b0;
        @(negedge hclk);
        chk("idle_xfer_ready", 64'(hreadyout), 64'd1);
        chk("idle_xfer_resp", 64'(hresp), 64'd0);
        @(posedge hclk); #1;
        chk("idle_next_ready", 64'(hreadyout), 64'd1);
        chk("idle_next_req", 64'(mem_req), 64'd0);
        hsel = 1'b0;

        repeat (3) @(posedge hclk);
        #1;
        chk("mem_queue_left", 64'(exp_mem.size()), 64'd0);
        chk("rsp_queue_left", 64'(exp_rsp.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ahbl_slv_mem_bridge.md
Name: ahbl_slv_mem_bridge

Overview:
Downstream consumer of the AHB-Lite slave interface bundle. It terminates AHB-Lite transfers and turns them into single-beat requests on a simple request/grant/rvalid memory port (SRAM or register-file backend). It generates hreadyout wait states and the two-cycle ERROR response, and registers read data.

Parameters:
AW, 32, AHB address width
DW, 32, data width; legal values are 32 and 64
BW, DW/8, number of byte lanes (derived)
MAW, AW-$clog2(BW), memory word-address width (derived)

Ports:
hclk  in  1  clock
hreset  in  1  asynchronous active-high reset
hsel  in  1  slave select
htrans  in  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
haddr  in  AW  address-phase address
hsize  in  3  transfer size
hburst  in  3  burst type; accepted, no effect
hprot  in  2  protection; accepted, no effect
hwrite  in  1  1 = write
hwdata  in  DW  write data, valid in data phase
hready  in  1  bus-level ready; address phase is accepted only when this is 1
hreadyout  out  1  slave ready
hresp  out  2  00 OKAY, 01 ERROR
hrdata  out  DW  read data, registered
mem_req  out  1  memory request
mem_we  out  1  1 = write
mem_addr  out  MAW  word address
mem_be  out  BW  byte enables
mem_wdata  out  DW  write data
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  read data valid; earliest one cycle after gnt
mem_rdata  in  DW  read data

Behaviour:
- Reset values (asynchronous, while hreset=1): hreadyout=1, hresp=00, hrdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0. FSM is in IDLE. Any in-flight transfer is dropped and a late mem_rvalid is ignored.
- Accept condition is hsel & htrans[1] & hready. On accept, register haddr, hsize and hwrite.
- IDLE, BUSY, or hsel=0 gives a zero-wait OKAY response with no memory activity.
- Error check at accept time, on either of:
  - hsize > $clog2(BW)
  - haddr not aligned to 2^hsize
  On error, go to ERR1 with no memory access.
- Byte enables: BW-bit mask with 2^hsize bits set, shifted left by haddr[$clog2(BW)-1:0].
- mem_addr = registered haddr[AW-1:$clog2(BW)].
- FSM states: IDLE, WR, RD_REQ, RD_WAIT, RD_DONE, ERR1, ERR2.
  - IDLE: hreadyout=1, hresp=00. Next state on accept:
    - error → ERR1
    - write → WR
    - read → RD_REQ
  - WR: mem_req=1, mem_we=1, mem_wdata=hwdata (combinational), hreadyout=mem_gnt. Stay in WR until mem_gnt. On gnt, the next state is chosen from the current-cycle accept as in IDLE (pipelined back-to-back), otherwise IDLE.
  - RD_REQ: mem_req=1, mem_we=0, hreadyout=0. On mem_gnt → RD_WAIT.
  - RD_WAIT: mem_req=0, hreadyout=0. On mem_rvalid, hrdata <= mem_rdata and go to RD_DONE.
  - RD_DONE: hreadyout=1, hresp=00, hrdata stable. Next state chosen as in IDLE.
  - ERR1: hreadyout=0, hresp=01 → ERR2.
  - ERR2: hreadyout=1, hresp=01. Next state chosen as in IDLE.
- Latency:
  - Write with mem_gnt=1 completes in a single data-phase cycle (zero wait).
  - Read with immediate gnt and rvalid one cycle later takes 3 data-phase cycles: 2 waits, then ready.
- hrdata holds its last value outside RD_DONE.
- mem_req drops in the cycle after the granting cycle unless a new transfer was accepted.
- mem_rvalid is ignored in every state except RD_WAIT.
- If the master drives htrans=IDLE while hreadyout=0, no effect: transfers are only captured when hready=1.

Test Plan:
- Word write to 0x0000_0010, data 0xDEAD_BEEF, mem_gnt=1 → one cycle with mem_req=1, mem_we=1, mem_addr=0x4, mem_be=1111, mem_wdata=0xDEADBEEF; hreadyout=1, hresp=00.
- Word read at 0x10, mem_gnt held 0 for 2 cycles, rvalid 3 cycles after gnt, rdata=0x1234_5678 → hreadyout low for 6 cycles, then 1 with hrdata=0x12345678, hresp=00.
- Byte write at 0x13 (hsize=0), then halfword write at 0x12 → mem_be=1000, then mem_be=1100.
- Halfword access at 0x01 → 2-cycle ERROR: (hreadyout=0, hresp=01), then (1, 01); mem_req never asserted. Same result for hsize=3 when DW=32.
- Back-to-back NONSEQ write 0x20 then read 0x24, gnt always 1 → write data phase completes zero-wait, read mem_req issued the next cycle with mem_addr=0x9.
- hreset pulsed during RD_WAIT, then rvalid arrives → all outputs at reset values, FSM in IDLE, hrdata stays 0; a following IDLE transfer gets an OKAY zero-wait response.
